spi_shifter: RTL and testbench

Bit-level SPI master engine directly downstream of the `spi` register block. Takes a byte plus baud/mode settings on a single-cycle start strobe, and generates SPI_CLK, SPI_MOSI and SPI_nSS. Samples SPI_MISO and returns the received byte with a one-cycle done pulse. The register block drives the inputs from SPIDR/SPIBR/SPICR and uses done to raise the SPISR flag and irq.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_baud_gen.sv | 48 ++++
 rtl/spi_shifter.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_shifter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master shifter.
//   - FSM state encoding for spi_shifter
//   - default data and baud-divider widths
//   - transfer length in SCK edges
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned SPI_DIV_W  = 4;

    // One leading plus one trailing SCK edge per data bit.
    localparam int unsigned SPI_XFER_EDGES = 2 * SPI_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: half-period timer for the SPI serial clock.
// Counts 0..div and wraps; tick marks the last cycle of each half-period,
// so one half-period lasts div+1 clk cycles.
// Ports:
//   clk    in   system clock (rising edge)
//   rst    in   asynchronous active-high reset
//   enable in   count while high
//   clear  in   restart the half-period from zero (wins over enable)
//   div    in   half-period length minus one
//   tick   out  combinational, high in the final cycle of a half-period
module spi_baud_gen #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_end_c;

    assign at_end_c = (cnt_q == div);

    // Next count: clear restarts, otherwise count and wrap at div.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_end_c ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && !clear && at_end_c;

endmodule

// File: rtl/spi_shifter.sv
// spi_shifter: bit-level SPI master engine.
// A start strobe in IDLE latches the byte and the baud/mode settings, then
// the FSM walks IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE, driving
// SPI_CLK/SPI_MOSI/SPI_nSS and shifting SPI_MISO into the shift register.
// Optional feature macro: SPI_LSB_FIRST_EN (when defined, lsb_first=1
// selects LSB-first order; when undefined lsb_first is ignored).
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         one-cycle request, honoured only in IDLE
//   tx_data       byte to send (latched on accepted start)
//   div           half-period length minus one (latched on start)
//   cpol, cpha    SPI mode (latched on start)
//   lsb_first     bit order select
//   rx_data       received byte, updated in the DONE cycle
//   busy          high whenever the FSM is not IDLE
//   done          one-cycle pulse in the DONE cycle
//   SPI_MISO      serial data in
//   SPI_MOSI      serial data out
//   SPI_CLK       serial clock
//   SPI_nSS       slave select, active low
module spi_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned DIV_W  = SPI_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    input  logic              SPI_MISO,
    output logic              SPI_MOSI,
    output logic              SPI_CLK,
    output logic              SPI_nSS
);

    localparam int unsigned EDGES = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(EDGES) + 1;

    spi_state_e state_q, state_d;

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              sample_q, sample_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              nss_q, nss_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              lsb_q;
    logic              lsb_in_c;
    logic              accept_c;
    logic              tick_c;
    logic              baud_en_c;
    logic              baud_clear_c;
    logic              leading_c;
    logic              last_edge_c;

    // Bit to present on MOSI for the selected order.
    function automatic logic out_bit(input logic [DATA_W-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATA_W-1];
    endfunction

    // Shift one received bit in; the opposite end is the one just sent.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr,
                                                   input logic              b,
                                                   input logic              lsb);
        if (lsb) begin
            return {b, sr[DATA_W-1:1]};
        end
        return {sr[DATA_W-2:0], b};
    endfunction

    assign accept_c = (state_q == ST_IDLE) && start;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in_c = lsb_first;

    // Bit order is part of the configuration latched on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else if (accept_c) begin
            lsb_q <= lsb_first;
        end
    end
`else
    logic unused_lsb_first;

    // Port kept for a stable interface; order is fixed MSB-first.
    assign unused_lsb_first = lsb_first;
    assign lsb_in_c         = 1'b0;
    assign lsb_q            = 1'b0;
`endif

    assign baud_en_c   = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    assign leading_c   = ~bit_cnt_q[0];
    assign last_edge_c = (bit_cnt_q == CNT_W'(EDGES - 1));

    spi_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (baud_en_c),
        .clear  (baud_clear_c),
        .div    (div_q),
        .tick   (tick_c)
    );

    // Next-state and next-output logic; all outputs are registered from *_d.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        rx_d         = rx_q;
        bit_cnt_d    = bit_cnt_q;
        div_d        = div_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        sample_d     = sample_q;
        sck_d        = sck_q;
        mosi_d       = mosi_q;
        nss_d        = nss_q;
        baud_clear_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                nss_d  = 1'b1;
                mosi_d = 1'b0;
                sck_d  = cpol_q;
                if (start) begin
                    div_d        = div;
                    cpol_d       = cpol;
                    cpha_d       = cpha;
                    sr_d         = tx_data;
                    bit_cnt_d    = '0;
                    baud_clear_c = 1'b1;
                    sck_d        = cpol;
                    nss_d        = 1'b0;
                    // cpha=0 slaves sample on the first edge, so bit 0 goes out in SETUP.
                    mosi_d       = cpha ? 1'b0 : out_bit(tx_data, lsb_in_c);
                    state_d      = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tick_c) begin
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (tick_c) begin
                    sck_d     = ~sck_q;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (leading_c) begin
                        if (!cpha_q) begin
                            sample_d = SPI_MISO;
                        end else begin
                            mosi_d = out_bit(sr_q, lsb_q);
                        end
                    end else begin
                        if (!cpha_q) begin
                            // Sampled bit is held until now so MOSI stays put across the leading edge.
                            sr_d = shift_in(sr_q, sample_q, lsb_q);
                            if (!last_edge_c) begin
                                mosi_d = out_bit(sr_d, lsb_q);
                            end
                        end else begin
                            sr_d = shift_in(sr_q, SPI_MISO, lsb_q);
                        end
                    end
                    if (last_edge_c) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (tick_c) begin
                    nss_d   = 1'b1;
                    mosi_d  = 1'b0;
                    sck_d   = cpol_q;
                    rx_d    = sr_q;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sample_q  <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            nss_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sample_q  <= sample_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            nss_q     <= nss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rx_data  = rx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CLK  = sck_q;
    assign SPI_nSS  = nss_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: table of transfers plus hand-written
// sequences for ignored starts, back-to-back start and mid-transfer reset.
module tb_spi_shifter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic [3:0] div;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       SPI_MISO;
    logic       SPI_MOSI;
    logic       SPI_CLK;
    logic       SPI_nSS;

    logic       loop;
    logic       slv_miso;

    int checks = 0;
    int errors = 0;

    assign SPI_MISO = loop ? SPI_MOSI : slv_miso;

    spi_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_data   (tx_data),
        .div       (div),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .SPI_MISO  (SPI_MISO),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_CLK   (SPI_CLK),
        .SPI_nSS   (SPI_nSS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] tx;
        logic [3:0] dv;
        logic       cp;
        logic       ph;
        logic       lsb;
        logic       lp;
        logic [7:0] slv_tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_done;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Run one transfer starting at the current negedge; monitors the bus
    // each negedge and acts as a simple SPI slave when not looped back.
    task automatic run_xfer(input vec_t v, input bit poke);
        int         cyc, done_cyc, done_cnt, lead, trail, nss_low;
        int         first_lead, second_lead, unstable, sbit, half;
        logic [7:0] seen, rx_got;
        logic       prev_sck, prev_mosi, prev_nss, sck_setup, busy1;

        cyc = 0; done_cyc = -1; done_cnt = 0; lead = 0; trail = 0; nss_low = 0;
        first_lead = -1; second_lead = -1; unstable = 0; sbit = 0;
        seen = '0; rx_got = '0; sck_setup = 1'bx; busy1 = 1'bx;
        half = int'(v.dv) + 1;

        tx_data = v.tx; div = v.dv; cpol = v.cp; cpha = v.ph;
        lsb_first = v.lsb; loop = v.lp; slv_miso = 1'b0;
        start = 1'b1;
        prev_sck = SPI_CLK; prev_mosi = SPI_MOSI; prev_nss = SPI_nSS;

        while (cyc < 400 && (done_cyc < 0 || cyc <= done_cyc)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                sck_setup = SPI_CLK;
                busy1 = busy;
            end
            if (poke && cyc == 10) begin
                start = 1'b1; tx_data = 8'hFF; div = 4'hF; cpol = ~v.cp; cpha = ~v.ph;
            end
            if (poke && cyc == 11) begin
                start = 1'b0; tx_data = 8'h00;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) start = 1'b0;
            if (prev_nss === 1'b1 && SPI_nSS === 1'b0 && !v.ph) begin
                slv_miso = v.slv_tx[7];
                sbit = 1;
            end
            if (prev_nss === 1'b0 && SPI_nSS === 1'b0 && SPI_CLK !== prev_sck) begin
                if (SPI_CLK !== v.cp) begin
                    lead++;
                    if (first_lead < 0) first_lead = cyc;
                    else if (second_lead < 0) second_lead = cyc;
                    if (!v.ph) begin
                        seen = {seen[6:0], prev_mosi};
                        if (SPI_MOSI !== prev_mosi) unstable++;
                    end else if (sbit < 8) begin
                        slv_miso = v.slv_tx[3'(7 - sbit)];
                        sbit++;
                    end
                end else begin
                    trail++;
                    if (v.ph) begin
                        seen = {seen[6:0], prev_mosi};
                        if (SPI_MOSI !== prev_mosi) unstable++;
                    end else if (sbit < 8) begin
                        slv_miso = v.slv_tx[3'(7 - sbit)];
                        sbit++;
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    rx_got = rx_data;
                    if (poke) begin
                        start = 1'b1; tx_data = 8'h00;
                    end
                end
            end
            if (SPI_nSS === 1'b0) nss_low++;
            prev_sck = SPI_CLK; prev_mosi = SPI_MOSI; prev_nss = SPI_nSS;
        end
        start = 1'b0;

        check($sformatf("v%0d_rx", v.id), 32'(rx_got), 32'(v.exp_rx));
        check($sformatf("v%0d_rx_hold", v.id), 32'(rx_data), 32'(v.exp_rx));
        check($sformatf("v%0d_done_cycle", v.id), 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("v%0d_done_pulses", v.id), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d_mosi_bits", v.id), 32'(seen), 32'(v.exp_mosi));
        check($sformatf("v%0d_mosi_unstable", v.id), 32'(unstable), 32'd0);
        check($sformatf("v%0d_lead_edges", v.id), 32'(lead), 32'd8);
        check($sformatf("v%0d_trail_edges", v.id), 32'(trail), 32'd8);
        check($sformatf("v%0d_nss_low", v.id), 32'(nss_low), 32'(18 * half));
        check($sformatf("v%0d_sck_period", v.id), 32'(second_lead - first_lead), 32'(2 * half));
        check($sformatf("v%0d_sck_setup", v.id), 32'(sck_setup), 32'(v.cp));
        check($sformatf("v%0d_busy_rise", v.id), 32'(busy1), 32'd1);
        check($sformatf("v%0d_busy_after", v.id), 32'(busy), 32'd0);
        check($sformatf("v%0d_sck_idle", v.id), 32'(SPI_CLK), 32'(v.cp));
    endtask

    vec_t vecs[5];
    vec_t vpoke, vb2b, vpost;

    initial begin
        //            id  tx     div   cpol  cpha  lsb   loop  slv_tx rx     mosi   done
        vecs[0] = '{0, 8'hA5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 8'hA5, 19};
        vecs[1] = '{1, 8'h3C, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'hC3, 8'h3C, 73};
        vecs[2] = '{2, 8'h69, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5B, 8'h5B, 8'h69, 289};
        vecs[3] = '{3, 8'h81, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 8'h7E, 8'h81, 37};
`ifdef SPI_LSB_FIRST_EN
        vecs[4] = '{4, 8'h01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h80, 19};
`else
        vecs[4] = '{4, 8'h01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h01, 19};
`endif
        vpoke = '{5, 8'h5A, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 8'h5A, 37};
        vb2b  = '{6, 8'h96, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2D, 8'h2D, 8'h96, 19};
        vpost = '{7, 8'h3E, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h3E, 8'h3E, 55};

        rst = 1'b1; start = 1'b0; tx_data = '0; div = '0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; loop = 1'b1; slv_miso = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_nss", 32'(SPI_nSS), 32'd1);
        check("reset_sck", 32'(SPI_CLK), 32'd0);
        check("reset_mosi", 32'(SPI_MOSI), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rx", 32'(rx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], 1'b0);
            @(negedge clk);
        end

        // Starts mid-XFER and in DONE are ignored; next start in first IDLE cycle accepted.
        run_xfer(vpoke, 1'b1);
        run_xfer(vb2b, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a mode-2 transfer.
        div = 4'd2; cpol = 1'b1; cpha = 1'b0; tx_data = 8'hC6; loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_nss", 32'(SPI_nSS), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_nss", 32'(SPI_nSS), 32'd1);
        check("mid_rst_sck", 32'(SPI_CLK), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rx", 32'(rx_data), 32'd0);
        check("mid_rst_mosi", 32'(SPI_MOSI), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_xfer(vpost, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
